alu_bist_sequencer: RTL and testbench

Built-in self-test driver for the 2-bit ALU. It generates every operation word the ALU accepts, presents each one with a valid strobe, and waits a programmable settle time. It then samples the ALU's result and overflow outputs and compares them against an internal golden model, counting mismatches and recording the first failing vector. It sits on the ALU's input/output pins as the stimulus-and-check end of that interface, and runs on start requests from the top level.

---
 rtl/alu_bist_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_bist_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_sequencer.sv
// BIST sequencer for the 2-bit ALU: sweeps all 128 operation words, lets each settle,
// then checks {overflow, result} against a golden model and logs mismatches.
module alu_bist_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic [6:0]           op_word_o,
  output logic                 op_valid_o,
  input  logic [2:0]           alu_result_i,
  input  logic                 alu_overflow_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [6:0]           first_err_vec_o,
  output logic                 first_err_valid_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_e               state_q;
  logic [6:0]           vec_q;
  logic [3:0]           cnt_q;
  logic                 op_valid_q, busy_q, done_q, pass_q;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [6:0]           fev_q, fev_d;
  logic                 fevld_q, fevld_d;

  logic [1:0] a, b;
  logic [2:0] ctl, sum, gold_res;
  logic       mism;

  assign a   = vec_q[1:0];
  assign b   = vec_q[3:2];
  assign ctl = vec_q[6:4];
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    gold_res = 3'd0;
    case (ctl)
      3'd0: gold_res = sum;
      3'd1: gold_res = {1'b0, a} - {1'b0, b};
      3'd2: gold_res = {1'b0, a & b};
      3'd3: gold_res = {1'b0, a | b};
      3'd4: gold_res = {1'b0, a ^ b};
      3'd5: gold_res = {1'b0, ~a};
      3'd6: gold_res = {a, 1'b0};
      3'd7: gold_res = {2'b00, a[1]};
      default: gold_res = 3'd0;
    endcase
  end

  // Overflow is the carry out of A+B regardless of the selected operation.
  assign mism = {alu_overflow_i, alu_result_i} != {sum[2], gold_res};

  always_comb begin
    err_d   = err_q;
    fev_d   = fev_q;
    fevld_d = fevld_q;
    if (mism) begin
      if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
      if (!fevld_q) begin
        fev_d   = vec_q;
        fevld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fev_q      <= '0;
      fevld_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q    <= S_RUN;
            vec_q      <= '0;
            cnt_q      <= RELOAD;
            op_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fev_q      <= '0;
            fevld_q    <= 1'b0;
          end
        end
        S_RUN: begin
          if (cnt_q == 4'd0) begin
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevld_q <= fevld_d;
            if (vec_q != 7'd127) begin
              vec_q <= vec_q + 7'd1;
              cnt_q <= RELOAD;
            end else begin
              state_q    <= S_DONE;
              vec_q      <= '0;
              op_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              pass_q     <= (err_d == '0);
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign op_word_o         = vec_q;
  assign op_valid_o        = op_valid_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_count_o       = err_q;
  assign first_err_vec_o   = fev_q;
  assign first_err_valid_o = fevld_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Bench for alu_bist_sequencer: three instances (default, 4-bit counter, 3-cycle settle)
// share one behavioural ALU with selectable fault modes.
module tb_alu_bist_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   mode = 0;
  logic [127:0] mask = '0;

  always #5 clk = ~clk;

  logic [6:0] ow8, ow4, ow3;
  logic       ov8, ov4, ov3;
  logic [2:0] res8, res4, res3;
  logic       ovf8, ovf4, ovf3;
  logic       busy8, busy4, busy3, done8, done4, done3, pass8, pass4, pass3;
  logic [7:0] err8, err3;
  logic [3:0] err4;
  logic [6:0] fev8, fev4, fev3;
  logic       fv8, fv4, fv3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference golden behaviour written with plain integer arithmetic.
  function automatic logic [3:0] gold(input int i);
    int a, b, c, r;
    a = i % 4; b = (i / 4) % 4; c = i / 16;
    case (c)
      0: r = (a + b) % 8;
      1: r = (a - b + 8) % 8;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 3 - a;
      6: r = (a * 2) % 8;
      default: r = a / 2;
    endcase
    return {(a + b) >= 4, 3'(r)};
  endfunction

  function automatic logic [3:0] alu_fn(input logic [6:0] w, input int md, input logic [127:0] mk);
    logic [3:0] g;
    g = gold(int'(w));
    case (md)
      1: if (w == 7'h15) g[2:0] = ~g[2:0];
      2: g[3] = 1'b0;
      3: g = ~g;
      4: if (w == 7'h1C) g = 4'd0;
      5: if (mk[w]) g[0] = ~g[0];
      default: ;
    endcase
    return g;
  endfunction

  always_comb {ovf8, res8} = alu_fn(ow8, mode, mask);
  always_comb {ovf4, res4} = alu_fn(ow4, mode, mask);
  always_comb {ovf3, res3} = alu_fn(ow3, mode, mask);

  alu_bist_sequencer #(.SETTLE_CYCLES(2), .ERR_CNT_W(8)) u8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_word_o(ow8), .op_valid_o(ov8),
    .alu_result_i(res8), .alu_overflow_i(ovf8), .busy_o(busy8), .done_o(done8),
    .pass_o(pass8), .err_count_o(err8), .first_err_vec_o(fev8), .first_err_valid_o(fv8));

  alu_bist_sequencer #(.SETTLE_CYCLES(2), .ERR_CNT_W(4)) u4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_word_o(ow4), .op_valid_o(ov4),
    .alu_result_i(res4), .alu_overflow_i(ovf4), .busy_o(busy4), .done_o(done4),
    .pass_o(pass4), .err_count_o(err4), .first_err_vec_o(fev4), .first_err_valid_o(fv4));

  alu_bist_sequencer #(.SETTLE_CYCLES(3), .ERR_CNT_W(8)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_word_o(ow3), .op_valid_o(ov3),
    .alu_result_i(res3), .alu_overflow_i(ovf3), .busy_o(busy3), .done_o(done3),
    .pass_o(pass3), .err_count_o(err3), .first_err_vec_o(fev3), .first_err_valid_o(fv3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " op_word"}, {25'd0, ow8}, 0);
    chk({tag, " op_valid"}, {31'd0, ov8}, 0);
    chk({tag, " busy"}, {31'd0, busy8}, 0);
    chk({tag, " done"}, {31'd0, done8}, 0);
    chk({tag, " pass"}, {31'd0, pass8}, 0);
    chk({tag, " err"}, {24'd0, err8}, 0);
    chk({tag, " fev"}, {25'd0, fev8}, 0);
    chk({tag, " fv"}, {31'd0, fv8}, 0);
    chk({tag, " busy3"}, {31'd0, busy3}, 0);
  endtask

  task automatic run_and_check(input string tag, input int md, input int exp_err,
                               input int exp_first, input bit exp_fv, input bit pulse_mid);
    int nb8, nb3, c;
    mode = md;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({tag, " busy@start"}, {31'd0, busy8}, 1);
    chk({tag, " valid@start"}, {31'd0, ov8}, 1);
    chk({tag, " word@start"}, {25'd0, ow8}, 0);
    chk({tag, " done@start"}, {31'd0, done8}, 0);
    nb8 = 0; nb3 = 0; c = 0;
    while (!(done8 && done4 && done3) && c < 1000) begin
      if (busy8) nb8++;
      if (busy3) nb3++;
      start = pulse_mid && (c == 100);
      @(posedge clk); #1; c++;
    end
    start = 1'b0;
    chk({tag, " timeout"}, {31'd0, c < 1000}, 1);
    chk({tag, " busy cycles s2"}, nb8, 256);
    chk({tag, " busy cycles s3"}, nb3, 384);
    chk({tag, " busy@done"}, {31'd0, busy8}, 0);
    chk({tag, " valid@done"}, {31'd0, ov8}, 0);
    chk({tag, " word@done"}, {25'd0, ow8}, 0);
    chk({tag, " err8"}, {24'd0, err8}, exp_err);
    chk({tag, " err3"}, {24'd0, err3}, exp_err);
    chk({tag, " err4 sat"}, {28'd0, err4}, (exp_err > 15) ? 15 : exp_err);
    chk({tag, " pass8"}, {31'd0, pass8}, exp_err == 0);
    chk({tag, " pass4"}, {31'd0, pass4}, exp_err == 0);
    chk({tag, " fv8"}, {31'd0, fv8}, exp_fv);
    chk({tag, " fv4"}, {31'd0, fv4}, exp_fv);
    if (exp_fv) begin
      chk({tag, " fev8"}, {25'd0, fev8}, exp_first);
      chk({tag, " fev3"}, {25'd0, fev3}, exp_first);
      chk({tag, " fev4"}, {25'd0, fev4}, exp_first);
    end
    repeat (5) @(posedge clk);
    #1;
    chk({tag, " done held"}, {31'd0, done8}, 1);
    chk({tag, " err held"}, {24'd0, err8}, exp_err);
  endtask

  typedef struct {
    string nm;
    int    md;
    int    exp_err;
    int    exp_first;
    bit    exp_fv;
    bit    pulse_mid;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int c, e, f;
    bit fvv;
    tbl[0] = '{"clean",       0, 0,   0,     0, 0};
    tbl[1] = '{"flip15",      1, 1,   'h15,  1, 0};
    tbl[2] = '{"ovf0",        2, 48,  'h07,  1, 0};
    tbl[3] = '{"invert",      3, 128, 'h00,  1, 0};
    tbl[4] = '{"sub wrap",    4, 1,   'h1C,  1, 0};
    tbl[5] = '{"midstart",    0, 0,   0,     0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    // Reset mid-run at op_word 40, then a clean run must still pass.
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    c = 0;
    while (ow8 != 7'd40 && c < 200) begin
      @(posedge clk); #1; c++;
    end
    chk("reach word 40", {25'd0, ow8}, 40);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk_reset_state("midrun rst");
    run_and_check("post-rst", 0, 0, 0, 0, 0);

    for (int t = 0; t < 6; t++)
      run_and_check(tbl[t].nm, tbl[t].md, tbl[t].exp_err, tbl[t].exp_first,
                    tbl[t].exp_fv, tbl[t].pulse_mid);

    // Random fault sets, expectations from the reference model.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 128; i++) mask[i] = ($urandom_range(0, 5) == 0);
      e = 0; f = 0; fvv = 0;
      for (int i = 0; i < 128; i++)
        if (alu_fn(7'(i), 5, mask) != gold(i)) begin
          if (!fvv) begin f = i; fvv = 1; end
          e++;
        end
      run_and_check($sformatf("rand%0d", r), 5, e, f, fvv, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
